// File: rtl/subcode_sequencer.sv
// CD-ROM P-W subchannel capture: per-EFFK 8-pulse SCCK burst, SBCP deserialiser,
// SCOR block tagging, FWFT symbol FIFO and per-block interrupt.
module subcode_sequencer #(
    parameter  int SCCK_HALF     = 2,
    parameter  int FRAME_SYMBOLS = 98,
    parameter  int FIFO_DEPTH    = 16,
    localparam int AW            = $clog2(FIFO_DEPTH)
) (
    input  logic        CCK,
    input  logic        IFRST_n,
    input  logic        EN,
    input  logic        EFFK,
    input  logic        SCOR,
    input  logic        SBCP,
    output logic        SCCK,
    output logic [7:0]  SUB_DATA,
    output logic        SUB_SYNC,
    output logic        SUB_VALID,
    input  logic        SUB_RD,
    output logic [AW:0] LEVEL,
    output logic        OVF,
    output logic        MISS,
    output logic        INT_n,
    input  logic        INT_ACK
);

    localparam int PW = (SCCK_HALF > 1) ? $clog2(SCCK_HALF) : 1;
    localparam int CW = $clog2(FRAME_SYMBOLS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_STORE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [1:0]    r_effk_s;
    logic [1:0]    r_scor_s;
    logic [1:0]    r_sbcp_s;
    logic          r_effk_d;
    logic          r_scor_d;
    logic [PW-1:0] r_phase;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_scck;
    logic          r_sync_pend;
    logic [CW-1:0] r_symcnt;
    logic          r_int;
    logic          r_ovf;
    logic          r_miss;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_effk_rise;
    logic w_scor_rise;
    logic w_last;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_push_ok;
    logic w_wrap;
    logic [AW-1:0] w_rd_idx;

    assign w_effk_rise = r_effk_s[1] & ~r_effk_d;
    assign w_scor_rise = r_scor_s[1] & ~r_scor_d;
    assign w_last      = (r_phase == PW'(SCCK_HALF - 1));
    assign w_push      = (r_state == ST_STORE);
    assign w_pop       = SUB_RD & (r_cnt != '0);
    assign w_full      = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_wrap      = (r_symcnt == CW'(FRAME_SYMBOLS - 1));

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_effk_rise && EN) w_state_nx = ST_HI;
            ST_HI:    if (w_last) w_state_nx = ST_LO;
            ST_LO: begin
                if (w_last)
                    w_state_nx = (r_bit == 3'd7) ? ST_STORE : ST_HI;
            end
            ST_STORE: w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CCK or negedge IFRST_n) begin
        if (!IFRST_n) begin
            r_effk_s <= '0;
            r_scor_s <= '0;
            r_sbcp_s <= '0;
            r_effk_d <= 1'b0;
            r_scor_d <= 1'b0;
        end else begin
            r_effk_s <= {r_effk_s[0], EFFK};
            r_scor_s <= {r_scor_s[0], SCOR};
            r_sbcp_s <= {r_sbcp_s[0], SBCP};
            r_effk_d <= r_effk_s[1];
            r_scor_d <= r_scor_s[1];
        end
    end

    // SCCK is registered from the next state so the pin never glitches.
    always_ff @(posedge CCK or negedge IFRST_n) begin
        if (!IFRST_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_scck  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_scck  <= (w_state_nx == ST_HI);
            if (r_state == ST_HI || r_state == ST_LO)
                r_phase <= w_last ? '0 : r_phase + PW'(1);
            else
                r_phase <= '0;
            if (r_state == ST_IDLE)
                r_bit <= '0;
            else if (r_state == ST_LO && w_last)
                r_bit <= r_bit + 3'd1;
            if (r_state == ST_LO && w_last)
                r_shift <= {r_shift[6:0], r_sbcp_s[1]};
        end
    end

    // A SCOR edge coinciding with STORE tags the following symbol.
    always_ff @(posedge CCK or negedge IFRST_n) begin
        if (!IFRST_n) begin
            r_sync_pend <= 1'b0;
            r_symcnt    <= '0;
            r_int       <= 1'b0;
            r_ovf       <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            if (w_scor_rise)
                r_sync_pend <= 1'b1;
            else if (w_push)
                r_sync_pend <= 1'b0;
            if (w_scor_rise)
                r_symcnt <= '0;
            else if (w_push_ok)
                r_symcnt <= w_wrap ? '0 : r_symcnt + CW'(1);
            if (w_push_ok && w_wrap)
                r_int <= 1'b1;
            else if (INT_ACK)
                r_int <= 1'b0;
            if (w_push && !w_push_ok)
                r_ovf <= 1'b1;
            else if (INT_ACK)
                r_ovf <= 1'b0;
            if (w_effk_rise && r_state != ST_IDLE)
                r_miss <= 1'b1;
            else if (INT_ACK)
                r_miss <= 1'b0;
        end
    end

    always_ff @(posedge CCK or negedge IFRST_n) begin
        if (!IFRST_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wp] <= {r_sync_pend, r_shift};
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            if (w_push_ok && !w_pop)
                r_cnt <= r_cnt + (AW+1)'(1);
            else if (!w_push_ok && w_pop)
                r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

    // When empty, the slot behind the read pointer still holds the last head.
    assign w_rd_idx  = (r_cnt == '0) ? r_rp - AW'(1) : r_rp;
    assign SUB_DATA  = r_mem[w_rd_idx][7:0];
    assign SUB_SYNC  = r_mem[w_rd_idx][8];
    assign SUB_VALID = (r_cnt != '0);
    assign LEVEL     = r_cnt;
    assign SCCK      = r_scck;
    assign OVF       = r_ovf;
    assign MISS      = r_miss;
    assign INT_n     = ~r_int;

endmodule

// File: doc/subcode_sequencer.md
Name: subcode_sequencer

Overview:
- Controls the CD-ROM serial subchannel (P-W) path, replacing free-running SCCK generation with a sequenced capture engine.
- On each EFFK symbol strobe it issues exactly 8 SCCK pulses, deserialises SBCP MSB-first (P first), and tags the symbol with SCOR block sync.
- Buffers symbols in a first-word-fall-through FIFO for the host/DMAC side and raises an interrupt per completed 98-symbol subcode block.

Parameters:
SCCK_HALF, 2, CCK cycles per SCCK high phase and per low phase; legal minimum 2.
FRAME_SYMBOLS, 98, symbols per subcode block.
FIFO_DEPTH, 16, FIFO entries; power of two, at least 4.

Ports:
CCK  input  1  system clock; all state on rising edge.
IFRST_n  input  1  asynchronous active-low reset.
EN  input  1  capture enable.
EFFK  input  1  async symbol strobe from drive.
SCOR  input  1  async block sync from drive.
SBCP  input  1  async serial subchannel data.
SCCK  output  1  serial subchannel clock to drive.
SUB_DATA  output  8  FIFO head symbol, bit7=P ... bit0=W.
SUB_SYNC  output  1  FIFO head is the first symbol after SCOR.
SUB_VALID  output  1  FIFO not empty.
SUB_RD  input  1  pop FIFO head.
LEVEL  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
OVF  output  1  sticky: symbol dropped because FIFO was full.
MISS  output  1  sticky: EFFK edge arrived while busy.
INT_n  output  1  active-low block-complete interrupt, level.
INT_ACK  input  1  one-cycle pulse; clears INT_n, OVF and MISS.

Behaviour:
Reset and synchronisation:
- EFFK, SCOR and SBCP each pass through a 2-flop synchroniser. Edge detection uses the synchronised values.
- Reset values: SCCK=0, SUB_DATA=0, SUB_SYNC=0, SUB_VALID=0, LEVEL=0, OVF=0, MISS=0, INT_n=1. FIFO empty, symbol counter 0, state IDLE, sync-pending flag 0.

State machine (IDLE, HI, LO, STORE):
- IDLE: when a synchronised EFFK rising edge occurs and EN=1, go to HI with bit count 0. If EN=0, the edge is ignored silently.
- HI: SCCK=1 for SCCK_HALF cycles, then go to LO.
- LO: SCCK=0 for SCCK_HALF cycles. On the last LO cycle, shift the synchronised SBCP into the shift register LSB, shifting left. After 8 bits go to STORE; otherwise increment the bit count and go to HI.
- STORE: one cycle. Push {sync-pending, shift register} to the FIFO, clear sync-pending, then go to IDLE.
- An EFFK rising edge in HI, LO or STORE sets MISS and is discarded; it is never queued.
- Symbol period is 2*8*SCCK_HALF+1 cycles (default 33). Latency from synchronised EFFK edge to SUB_VALID is one cycle after STORE.
- EN deasserted mid-symbol: the current symbol completes and is stored; no new symbol starts.

Block sync and counting:
- A synchronised SCOR rising edge sets sync-pending and resets the symbol counter to 0.
- If the SCOR edge and STORE fall in the same cycle, the storing symbol keeps the old flag. The new sync applies to the next symbol.
- The symbol counter increments on every successful push and wraps to 0 after FRAME_SYMBOLS-1.
- A push taking the counter from FRAME_SYMBOLS-1 to 0 drives INT_n=0. INT_n holds until INT_ACK.
- INT_ACK in the same cycle as a new block completion leaves INT_n=0 (set wins).

FIFO:
- First-word fall-through: SUB_DATA and SUB_SYNC show the head whenever SUB_VALID=1. Contents are don't-care when empty; they hold the last value.
- SUB_RD with SUB_VALID=1 pops on that clock. SUB_RD when empty is ignored.
- A push when full, with no pop in the same cycle, is dropped and sets OVF. A dropped push does not advance the symbol counter.
- Push and pop in the same cycle at full are both accepted; LEVEL is unchanged.
- LEVEL ranges 0..FIFO_DEPTH. Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- OVF and MISS: a set event in the same cycle as INT_ACK leaves the flag set.

Reset assertion mid-operation:
- Asserting IFRST_n at any time forces reset values immediately, including SCCK low without completing the pulse. The FIFO is flushed.

Test Plan:
- Reset, EN=1, one EFFK pulse with SBCP serial 1,0,1,1,0,0,1,0 presented per SCCK rise -> exactly 8 SCCK pulses of 2 high/2 low cycles; SUB_DATA=0xB2, SUB_SYNC=0, LEVEL=1.
- SCOR pulse, then 98 EFFK symbols of value n -> first entry has SUB_SYNC=1 and the rest 0; INT_n falls after the 98th push. INT_ACK -> INT_n=1.
- 17 symbols with no reads, FIFO_DEPTH=16 -> LEVEL=16, OVF=1, 17th symbol absent. Then 16 reads return symbols 1..16 in order and LEVEL=0.
- Second EFFK edge 10 cycles after the first -> MISS=1, still only 8 SCCK pulses, one symbol stored.
- SUB_RD held high while empty, then a push and a pop in the same cycle at LEVEL=16 -> no underflow, LEVEL stays 16, OVF unchanged.
- IFRST_n pulsed low during the 5th SCCK high phase -> SCCK=0 immediately, LEVEL=0, INT_n=1. Next EFFK produces a clean 8-pulse symbol.
